alu_sweep_checker: RTL and testbench

//   Hardware self-check for the 4-bit ALU. On start it latches one operand pair and

---
 rtl/alu_sweep_checker.sv | 124 ++++++++++++
 tb/tb_alu_sweep_checker.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_sweep_checker.sv
// Built-in self-check for the 4-bit ALU: sweeps all eight op selects on one latched operand pair
// and compares each {carry,Y} result against an internal golden model.
module alu_sweep_checker #(
    parameter int unsigned DW            = 4,
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] a_in,
    input  logic [DW-1:0] b_in,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic [2:0]    alu_sel,
    input  logic [DW-1:0] alu_y,
    input  logic          alu_carry,
    output logic          busy,
    output logic          done,
    output logic [7:0]    fail_mask,
    output logic [3:0]    err_count,
    output logic          pass
);

    localparam int unsigned    CW       = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0]  CNT_LOAD = CW'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        FINISH
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] cnt;
    logic [DW:0]   golden;
    logic          mismatch;

    // Golden result is DW+1 bits wide: the top bit is the expected carry.
    always_comb begin
        golden = '0;
        case (alu_sel)
            3'd0: golden = {1'b0, alu_a} + {1'b0, alu_b};
            3'd1: golden = {1'b0, alu_a} + {1'b0, ~alu_b} + (DW+1)'(1);
            3'd2: golden = {1'b0, alu_a & alu_b};
            3'd3: golden = {1'b0, alu_a | alu_b};
            3'd4: golden = {1'b0, alu_a ^ alu_b};
            3'd5: golden = {1'b0, ~alu_a};
            3'd6: golden = {alu_b, 1'b0};
            3'd7: golden = {alu_b[0], 1'b0, alu_b[DW-1:1]};
            default: golden = '0;
        endcase
    end

    assign mismatch = ({alu_carry, alu_y} != golden);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SETTLE;
            SETTLE:  if (cnt == '0) state_next = SAMPLE;
            SAMPLE:  state_next = (alu_sel == 3'd7) ? FINISH : SETTLE;
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_a     <= '0;
            alu_b     <= '0;
            alu_sel   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            fail_mask <= '0;
            err_count <= '0;
            pass      <= 1'b0;
            cnt       <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        alu_a     <= a_in;
                        alu_b     <= b_in;
                        alu_sel   <= '0;
                        fail_mask <= '0;
                        err_count <= '0;
                        pass      <= 1'b0;
                        busy      <= 1'b1;
                        cnt       <= CNT_LOAD;
                    end
                end
                SETTLE: begin
                    if (cnt != '0) cnt <= cnt - CW'(1);
                end
                SAMPLE: begin
                    if (mismatch) begin
                        fail_mask[alu_sel] <= 1'b1;
                        err_count          <= err_count + 4'd1;
                    end
                    if (alu_sel != 3'd7) begin
                        alu_sel <= alu_sel + 3'd1;
                        cnt     <= CNT_LOAD;
                    end
                end
                FINISH: begin
                    // The last op's mismatch is already folded into fail_mask here.
                    busy <= 1'b0;
                    done <= 1'b1;
                    pass <= (fail_mask == '0);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sweep_checker.sv
// Randomized self-checking bench for alu_sweep_checker with a fault-injectable behavioural ALU,
// covering SETTLE_CYCLES of 1 and 3.
module tb_alu_sweep_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start1, start3;
    logic [3:0] a_in, b_in;
    logic [7:0] corrupt;
    logic       stuck;
    bit         cur;

    logic [3:0] a1, b1, y1, e1;
    logic [2:0] s1;
    logic       c1, busy1, done1, pass1;
    logic [7:0] m1;
    logic [3:0] a3, b3, y3, e3;
    logic [2:0] s3;
    logic       c3, busy3, done3, pass3;
    logic [7:0] m3;

    int unsigned tests = 0;
    int unsigned fails = 0;
    logic [4:0]  obs [8];

    // Spec-level results with plain integer arithmetic; bit 4 is the carry.
    function automatic logic [4:0] golden(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
        int unsigned ia = a;
        int unsigned ib = b;
        int unsigned r;
        case (op)
            3'd0: r = ia + ib;
            3'd1: r = ia + 16 - ib;
            3'd2: r = ia & ib;
            3'd3: r = ia | ib;
            3'd4: r = ia ^ ib;
            3'd5: r = 15 - ia;
            3'd6: r = ib * 2;
            default: r = (ib % 2) * 16 + ib / 2;
        endcase
        return 5'(r % 32);
    endfunction

    function automatic logic [4:0] alu_model(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op,
                                             input logic [7:0] cor, input logic stk);
        logic [4:0] r;
        r = golden(a, b, op);
        if (cor[op]) r = r ^ (op[0] ? 5'b10000 : 5'b00010);
        if (stk) r[4] = 1'b0;
        return r;
    endfunction

    assign {c1, y1} = alu_model(a1, b1, s1, corrupt, stuck);
    assign {c3, y3} = alu_model(a3, b3, s3, corrupt, stuck);

    alu_sweep_checker #(.DW(4), .SETTLE_CYCLES(1)) dut (
        .clk(clk), .rst(rst), .start(start1), .a_in(a_in), .b_in(b_in),
        .alu_a(a1), .alu_b(b1), .alu_sel(s1), .alu_y(y1), .alu_carry(c1),
        .busy(busy1), .done(done1), .fail_mask(m1), .err_count(e1), .pass(pass1)
    );

    alu_sweep_checker #(.DW(4), .SETTLE_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .a_in(a_in), .b_in(b_in),
        .alu_a(a3), .alu_b(b3), .alu_sel(s3), .alu_y(y3), .alu_carry(c3),
        .busy(busy3), .done(done3), .fail_mask(m3), .err_count(e3), .pass(pass3)
    );

    logic [3:0] m_a, m_b, m_y, m_e;
    logic [2:0] m_s;
    logic       m_c, m_busy, m_done, m_pass;
    logic [7:0] m_m;
    assign m_a    = cur ? a3 : a1;
    assign m_b    = cur ? b3 : b1;
    assign m_y    = cur ? y3 : y1;
    assign m_c    = cur ? c3 : c1;
    assign m_e    = cur ? e3 : e1;
    assign m_s    = cur ? s3 : s1;
    assign m_busy = cur ? busy3 : busy1;
    assign m_done = cur ? done3 : done1;
    assign m_pass = cur ? pass3 : pass1;
    assign m_m    = cur ? m3 : m1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run_sweep(input logic [3:0] a, input logic [3:0] b, input logic [7:0] cor, input logic stk);
        int unsigned per = cur ? 4 : 2;
        int unsigned k = 0;
        int unsigned bad = 0;
        int unsigned exp_sel;
        bit          got_done = 1'b0;
        logic [7:0]  exp_m = '0;
        for (int i = 0; i < 8; i++)
            if (alu_model(a, b, 3'(i), cor, stk) != golden(a, b, 3'(i))) exp_m[i] = 1'b1;
        @(negedge clk);
        a_in = a; b_in = b; corrupt = cor; stuck = stk;
        if (cur) start3 = 1'b1; else start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0; start3 = 1'b0;
        check("accept_busy", m_busy, 1);
        check("accept_clear", {m_m, m_e, m_pass}, 0);
        while (k < 100) begin
            if (m_done) begin got_done = 1'b1; break; end
            exp_sel = (k / per > 7) ? 7 : k / per;
            if (m_s != 3'(exp_sel) || m_a != a || m_b != b) bad++;
            obs[m_s] = {m_c, m_y};
            @(posedge clk); #1;
            k++;
        end
        check("done_seen", got_done, 1);
        check("latency", k, 8 * per + 1);
        check("op_sequence", bad, 0);
        check("fail_mask", m_m, exp_m);
        check("err_count", m_e, $countones(exp_m));
        check("pass", m_pass, exp_m == 8'h00);
        check("busy_end", m_busy, 0);
        @(posedge clk); #1;
        check("done_pulse", m_done, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned dones;
        bit          prev_done;
        bit          hit;

        rst = 1'b1; start1 = 1'b0; start3 = 1'b0; a_in = '0; b_in = '0;
        corrupt = '0; stuck = 1'b0; cur = 1'b0;
        for (int i = 0; i < 8; i++) obs[i] = '0;
        #12;
        check("reset_dut1", {a1, b1, s1, busy1, done1, m1, e1, pass1}, 0);
        check("reset_dut3", {a3, b3, s3, busy3, done3, m3, e3, pass3}, 0);
        @(negedge clk); rst = 1'b0;

        run_sweep(4'b0101, 4'b0011, 8'h00, 1'b0);

        run_sweep(4'b1100, 4'b0010, 8'h00, 1'b0);
        check("t2_sub", obs[1], 5'b11010);
        check("t2_shl", obs[6], 5'b00100);
        check("t2_shr", obs[7], 5'b00001);

        run_sweep(4'b1100, 4'b0110, 8'h00, 1'b1);
        check("t3_mask", m1, 8'b00000011);
        check("t3_err", e1, 2);

        // start held high across several sweeps
        @(negedge clk);
        a_in = 4'd7; b_in = 4'd9; corrupt = 8'h01; stuck = 1'b0; start1 = 1'b1;
        dones = 0; prev_done = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (prev_done) begin
                check("reaccept_clear", {m1, e1, pass1}, 0);
                check("reaccept_sel", s1, 0);
                check("reaccept_busy", busy1, 1);
            end
            if (done1) begin
                dones++;
                check("held_mask", m1, 8'h01);
            end
            prev_done = done1;
        end
        check("held_dones", dones, 2);
        @(negedge clk); start1 = 1'b0;
        hit = 1'b0;
        for (int k = 0; k < 40 && !hit; k++) begin
            @(posedge clk); #1;
            if (done1) hit = 1'b1;
        end
        check("held_drain", hit, 1);

        // asynchronous reset in the middle of a sweep
        @(negedge clk);
        a_in = 4'd3; b_in = 4'd10; corrupt = 8'h00; start1 = 1'b1;
        @(posedge clk); #1; start1 = 1'b0;
        hit = 1'b0;
        for (int k = 0; k < 30 && !hit; k++) begin
            @(posedge clk); #1;
            if (s1 == 3'd3) hit = 1'b1;
        end
        check("reach_sel3", hit, 1);
        #2; rst = 1'b1; #1;
        check("async_reset", {a1, b1, s1, busy1, done1, m1, e1, pass1}, 0);
        @(negedge clk); rst = 1'b0;
        dones = 0;
        for (int k = 0; k < 25; k++) begin
            @(posedge clk); #1;
            if (done1) dones++;
        end
        check("no_done_after_rst", dones, 0);
        run_sweep(4'b1001, 4'b1110, 8'h00, 1'b0);

        cur = 1'b1;
        run_sweep(4'b0101, 4'b0011, 8'h00, 1'b0);

        for (int n = 0; n < 24; n++) begin
            cur = 1'($urandom % 2);
            run_sweep(4'($urandom), 4'($urandom),
                      ($urandom % 3 == 0) ? 8'($urandom) : 8'h00,
                      1'($urandom % 4 == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
